// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage with single-outstanding req/ack data bus
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ans_i,
    input  logic        write_enable_i,
    input  logic [4:0]  write_addr_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] mem_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic [31:0] ans_o,
    output logic        write_enable_o,
    output logic [4:0]  write_addr_o,
    output logic        stall_o,
    output logic        except_align_o
);

    localparam logic [2:0] OP_LW  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_SW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_ans;
    logic        r_write_enable;
    logic [4:0]  r_write_addr;
    logic        r_except_align;

    state_t      w_state_nxt;
    logic        w_bus_req_nxt;
    logic        w_bus_we_nxt;
    logic [31:0] w_bus_addr_nxt;
    logic [3:0]  w_bus_sel_nxt;
    logic [31:0] w_bus_wdata_nxt;
    logic [31:0] w_ans_nxt;
    logic        w_write_enable_nxt;
    logic [4:0]  w_write_addr_nxt;
    logic        w_except_align_nxt;
    logic        w_stall;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_is_word;
    logic        w_misalign;
    logic [1:0]  w_lane;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [7:0]  w_rbyte;
    logic [31:0] w_load_data;

    assign w_is_load  = (mem_op_i == OP_LW) || (mem_op_i == OP_LB) || (mem_op_i == OP_LBU);
    assign w_is_store = (mem_op_i == OP_SW) || (mem_op_i == OP_SB);
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_is_word  = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
    assign w_misalign = w_is_word && (ans_i[1:0] != 2'b00);
    assign w_lane     = ans_i[1:0];
    assign w_sel      = w_is_word ? 4'b1111 : (4'b0001 << w_lane);
    assign w_wdata    = (mem_op_i == OP_SB) ? {4{mem_data_i[7:0]}} : mem_data_i;

    always_comb begin
        w_rbyte = bus_rdata_i[7:0];
        case (w_lane)
            2'd1:    w_rbyte = bus_rdata_i[15:8];
            2'd2:    w_rbyte = bus_rdata_i[23:16];
            2'd3:    w_rbyte = bus_rdata_i[31:24];
            default: w_rbyte = bus_rdata_i[7:0];
        endcase
    end

    always_comb begin
        w_load_data = bus_rdata_i;
        if (mem_op_i == OP_LB) begin
            w_load_data = {{24{w_rbyte[7]}}, w_rbyte};
        end else if (mem_op_i == OP_LBU) begin
            w_load_data = {24'd0, w_rbyte};
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_bus_req_nxt      = r_bus_req;
        w_bus_we_nxt       = r_bus_we;
        w_bus_addr_nxt     = r_bus_addr;
        w_bus_sel_nxt      = r_bus_sel;
        w_bus_wdata_nxt    = r_bus_wdata;
        w_ans_nxt          = r_ans;
        w_write_enable_nxt = r_write_enable;
        w_write_addr_nxt   = r_write_addr;
        w_except_align_nxt = 1'b0;
        w_stall            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_is_mem) begin
                    w_ans_nxt          = ans_i;
                    w_write_enable_nxt = write_enable_i;
                    w_write_addr_nxt   = write_addr_i;
                end else if (w_misalign) begin
                    w_write_enable_nxt = 1'b0;
                    w_except_align_nxt = 1'b1;
                end else begin
                    w_stall            = 1'b1;
                    w_state_nxt        = ST_WAIT;
                    w_bus_req_nxt      = 1'b1;
                    w_bus_we_nxt       = w_is_store;
                    w_bus_addr_nxt     = {ans_i[31:2], 2'b00};
                    w_bus_sel_nxt      = w_sel;
                    w_bus_wdata_nxt    = w_wdata;
                    w_write_enable_nxt = 1'b0;
                end
            end
            ST_WAIT: begin
                if (bus_ack_i) begin
                    w_state_nxt      = ST_IDLE;
                    w_bus_req_nxt    = 1'b0;
                    w_write_addr_nxt = write_addr_i;
                    // Upstream is frozen during the stall, so mem_op_i still names the active op.
                    if (w_is_load) begin
                        w_ans_nxt          = w_load_data;
                        w_write_enable_nxt = write_enable_i;
                    end else begin
                        w_ans_nxt          = ans_i;
                        w_write_enable_nxt = 1'b0;
                    end
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_bus_req      <= 1'b0;
            r_bus_we       <= 1'b0;
            r_bus_addr     <= 32'd0;
            r_bus_sel      <= 4'd0;
            r_bus_wdata    <= 32'd0;
            r_ans          <= 32'd0;
            r_write_enable <= 1'b0;
            r_write_addr   <= 5'd0;
            r_except_align <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_bus_req      <= w_bus_req_nxt;
            r_bus_we       <= w_bus_we_nxt;
            r_bus_addr     <= w_bus_addr_nxt;
            r_bus_sel      <= w_bus_sel_nxt;
            r_bus_wdata    <= w_bus_wdata_nxt;
            r_ans          <= w_ans_nxt;
            r_write_enable <= w_write_enable_nxt;
            r_write_addr   <= w_write_addr_nxt;
            r_except_align <= w_except_align_nxt;
        end
    end

    assign bus_req_o      = r_bus_req;
    assign bus_we_o       = r_bus_we;
    assign bus_addr_o     = r_bus_addr;
    assign bus_sel_o      = r_bus_sel;
    assign bus_wdata_o    = r_bus_wdata;
    assign ans_o          = r_ans;
    assign write_enable_o = r_write_enable;
    assign write_addr_o   = r_write_addr;
    assign except_align_o = r_except_align;
    assign stall_o        = w_stall;

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage that consumes the EX/MEM pipeline register outputs (result, write enable, write address) and drives the MEM/WB register inputs. For loads and stores it runs a single-outstanding request/acknowledge transaction on the data bus and stalls the pipeline until the bus acknowledges. For all other instructions it is a one-cycle registered pass-through.

## Interface
- No parameters. Data width is 32, register address width is 5.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-low; sampled on rising clk
- ans_i  in  32  EX result; effective address for memory ops
- write_enable_i  in  1  register write enable from EX/MEM
- write_addr_i  in  5  destination register from EX/MEM
- mem_op_i  in  3  0 none, 1 LW, 2 LB, 3 LBU, 4 SW, 5 SB; 6/7 treated as none
- mem_data_i  in  32  store data
- bus_req_o  out  1  request valid, held until ack
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word address {ans_i[31:2],2'b00}
- bus_sel_o  out  4  byte lane enables
- bus_wdata_o  out  32  write data
- bus_ack_i  in  1  one-cycle completion strobe
- bus_rdata_i  in  32  read data, valid with ack
- ans_o  out  32  result to MEM/WB
- write_enable_o  out  1  write enable to MEM/WB
- write_addr_o  out  5  destination to MEM/WB
- stall_o  out  1  combinational; upstream holds all inputs while high
- except_align_o  out  1  one-cycle misaligned-access pulse

## Operation
- States: IDLE, WAIT.
- IDLE, mem_op none: next edge ans_o<=ans_i, write_enable_o<=write_enable_i, write_addr_o<=write_addr_i. stall_o=0.
- IDLE, LW/SW with ans_i[1:0]!=0: no bus access. Next edge write_enable_o<=0 and except_align_o<=1 for one cycle. stall_o=0. State stays IDLE. Byte ops are never misaligned.
- IDLE, valid memory op: stall_o=1. Next edge: state<=WAIT; bus_req_o<=1; bus_we_o<=1 for SW/SB; bus_addr_o, bus_sel_o and bus_wdata_o latched; write_enable_o<=0 (bubble).
- Lanes: LW/SW sel=4'b1111. LB/LBU/SB sel=4'b0001<<ans_i[1:0]. SB wdata={4{mem_data_i[7:0]}}. SW wdata=mem_data_i.
- WAIT without ack: stall_o=1. Bus outputs held stable. write_enable_o stays 0.
- WAIT with ack: stall_o=0. Next edge: state<=IDLE, bus_req_o<=0, write_addr_o<=write_addr_i.
  - Loads: ans_o<=extracted data, write_enable_o<=write_enable_i.
  - Stores: write_enable_o<=0, ans_o<=ans_i.
- Load extraction: LW takes the whole word. LB/LBU take the byte selected by ans_i[1:0] (bits [8k+7:8k], little-endian). LB sign-extends; LBU zero-extends.
- bus_ack_i outside WAIT is ignored.
- Reset (rst=0 at an edge): state<=IDLE. All outputs <=0: ans_o, write_enable_o, write_addr_o, bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, except_align_o. Applies mid-transaction; the aborted access produces no writeback, and a later ack is ignored. stall_o=0 while in IDLE with no mem op.

## Timing
- Non-memory op: latency 1 cycle, no stall.
- Memory op acked in the k-th WAIT cycle (k>=1): stall_o is high for k cycles (the IDLE cycle plus k-1 WAIT cycles), low in the ack cycle. Result appears on the edge ending the ack cycle. Total latency is k+1 cycles.
- Minimum memory-op latency is 2 cycles; an ack coincident with the first bus_req_o cycle is legal.
- Back-to-back memory ops: the next op is evaluated in IDLE on the cycle after the ack. There is always exactly one IDLE cycle between transactions.
- Exactly one transaction is outstanding at a time. Request outputs never change while bus_req_o=1.

## Test plan
- Reset then pass-through: rst=0 for 2 cycles -> all outputs 0. Then ans_i=0x1234_5678, we=1, waddr=3, op none -> next edge ans_o=0x12345678, write_enable_o=1, write_addr_o=3, stall_o never high.
- LW, ack after 3 cycles: addr 0x100, rdata=0xDEAD_BEEF -> bus_addr_o=0x100, sel=1111, stall_o high 3 cycles, then ans_o=0xDEADBEEF, we=1.
- LB/LBU lane extraction: addr 0x203, rdata=0x80_00_00_00 -> LB gives 0xFFFF_FF80, sel=1000; LBU gives 0x0000_0080.
- SB: addr 0x301, mem_data_i=0xAB, ack on first WAIT cycle -> bus_we_o=1, sel=0010, wdata=0xABABABAB, write_enable_o stays 0, 2-cycle latency.
- Misaligned SW at 0x102 -> bus_req_o never asserted, except_align_o pulses once, write_enable_o=0, stall_o=0.
- Reset mid-WAIT: LW issued, rst=0 on the second WAIT cycle, ack the following cycle -> bus_req_o=0 and state IDLE after reset, ack ignored, write_enable_o remains 0.
